shifter_share_ctrl: RTL
=======================

Name: shifter_share_ctrl

Overview:
- Sequencing controller and 2-way round-robin arbiter for one shared SHIFTER_32 (inputs X, Sa, Arith, Right; combinational output Sh).
- Accepts shift commands from two requesters over valid/ready handshakes and drives the shifter.
- Implements rotate-right as two shifter passes.
- Returns each result with the requester ID through a one-entry output register with valid/ready.

Parameters:
- WIDTH, 32, data width; must match the shifter.
- SAW, 5, shift-amount width (log2 WIDTH).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Req0_Valid  in  1  requester 0 command valid.
- Req0_Ready  out  1  requester 0 command accepted this cycle.
- Req0_X  in  WIDTH  requester 0 operand.
- Req0_Sa  in  SAW  requester 0 shift amount.
- Req0_Op  in  2  requester 0 operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- Req1_Valid, Req1_Ready, Req1_X, Req1_Sa, Req1_Op: same as requester 0, for requester 1.
- Sh_X  out  WIDTH  to shifter X.
- Sh_Sa  out  SAW  to shifter Sa.
- Sh_Arith  out  1  to shifter Arith.
- Sh_Right  out  1  to shifter Right.
- Sh_Result  in  WIDTH  from shifter Sh (combinational).
- Res_Valid  out  1  result valid.
- Res_Ready  in  1  consumer accepts result.
- Res_Data  out  WIDTH  result.
- Res_Id  out  1  requester that issued the result.

Behaviour:
- States: IDLE, PASS1, PASS2, DONE. Operand registers: op_x, op_sa, op_code, op_id. Registers: partial (WIDTH), rr_last (1).
- Reset (async, immediate): state=IDLE, Res_Valid=0, Res_Data=0, Res_Id=0, rr_last=1 (requester 0 has priority first), partial=0, both Req*_Ready=0, all Sh_* outputs=0.
- Reset mid-operation discards the in-flight command; no result is emitted.
- IDLE, arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant requester !rr_last.
  - Req*_Ready is combinational: high only in IDLE, only for the granted requester, only while its Valid is high.
  - On handshake: latch operands and op_id, set rr_last=op_id, go to PASS1.
  - No Valid: stay in IDLE; Sh_* outputs=0.
- PASS1: Sh_X=op_x, Sh_Sa=op_sa.
  - SLL: Right=0, Arith=0. SRL: Right=1, Arith=0. SRA: Right=1, Arith=1. The edge captures Sh_Result into Res_Data, then goes to DONE.
  - ROR with op_sa=0: capture op_x into Res_Data, go to DONE (single pass).
  - ROR with op_sa!=0: Right=1, Arith=0; capture Sh_Result into partial, go to PASS2.
- PASS2 (ROR only): Sh_X=op_x, Sh_Sa=(0-op_sa) mod 2^SAW, Right=0, Arith=0. Capture Sh_Result | partial into Res_Data, go to DONE.
- DONE:
  - Res_Valid=1, Res_Id=op_id. Res_Data and Res_Id are held stable until Res_Ready.
  - On Res_Valid&&Res_Ready: Res_Valid=0 at the edge, go to IDLE.
  - No new command is accepted in DONE; there is no same-cycle bypass into IDLE.
  - Sh_* outputs=0 in DONE.
- Latency (accept edge = cycle 0):
  - SLL/SRL/SRA and ROR-by-0: Res_Valid at cycle 2.
  - ROR with op_sa!=0: Res_Valid at cycle 3.
  - Throughput: at most one command per 3 cycles (4 for ROR) with Res_Ready tied high.
- Requester inputs may change freely after acceptance; only latched copies are used.
- A held Valid with no grant is not lost: it stays pending until granted.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- Reset, then Req0 SLL X=0x0000_0001 Sa=31 -> Req0_Ready pulses 1 cycle; Res_Valid 2 cycles after accept; Res_Data=0x8000_0000, Res_Id=0.
- Req1 SRA X=0x8000_00F0 Sa=4 -> Res_Data=0xF800_000F; the same command with SRL -> Res_Data=0x0800_000F; Res_Id=1.
- Req0 ROR X=0x1234_5678 Sa=8 -> Sh_Sa=8 in PASS1, 24 in PASS2; Res_Data=0x7812_3456 after 3 cycles. ROR Sa=0 -> Res_Data=0x1234_5678 after 2 cycles.
- Both requesters valid continuously, Res_Ready=1 -> grant order 0,1,0,1; Res_Id alternates; no command dropped.
- Res_Ready held 0 for 5 cycles in DONE -> Res_Data/Res_Id stable, both Ready low; release -> next grant in IDLE the following cycle.
- Assert Rst during PASS2 of a ROR -> Res_Valid=0 immediately, state IDLE, requester 0 wins the next simultaneous request.

Source files
------------

// File: rtl/shifter_share_ctrl.sv
// shifter_share_ctrl: sequencing controller and 2-way round-robin arbiter for
// one shared combinational 32-bit shifter.
//
// Ports:
//   Clk, Rst                         clock, asynchronous active-high reset
//   ReqN_Valid/Ready/X/Sa/Op (N=0,1)  command handshakes from two requesters
//                                    (Op: 00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   Sh_X, Sh_Sa, Sh_Arith, Sh_Right  drive the shared shifter
//   Sh_Result                        shifter output (combinational)
//   Res_Valid/Ready/Data/Id          one-entry result register with requester ID
//
// Rotate-right is built from two shifter passes: a logical right shift by Sa,
// then a left shift by (-Sa mod WIDTH), OR-ed together.
module shifter_share_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SAW   = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Req0_Valid,
    output logic             Req0_Ready,
    input  logic [WIDTH-1:0] Req0_X,
    input  logic [SAW-1:0]   Req0_Sa,
    input  logic [1:0]       Req0_Op,
    input  logic             Req1_Valid,
    output logic             Req1_Ready,
    input  logic [WIDTH-1:0] Req1_X,
    input  logic [SAW-1:0]   Req1_Sa,
    input  logic [1:0]       Req1_Op,
    output logic [WIDTH-1:0] Sh_X,
    output logic [SAW-1:0]   Sh_Sa,
    output logic             Sh_Arith,
    output logic             Sh_Right,
    input  logic [WIDTH-1:0] Sh_Result,
    output logic             Res_Valid,
    input  logic             Res_Ready,
    output logic [WIDTH-1:0] Res_Data,
    output logic             Res_Id
);

    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRor = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_x_q, op_x_d;
    logic [SAW-1:0]   op_sa_q, op_sa_d;
    logic [1:0]       op_code_q, op_code_d;
    logic             op_id_q, op_id_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic             rr_last_q, rr_last_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;

    logic gnt_id;
    logic any_valid;

    // Requester 1 wins if it is alone, or if both ask and requester 0 went last.
    assign gnt_id    = Req1_Valid && (!Req0_Valid || !rr_last_q);
    assign any_valid = Req0_Valid || Req1_Valid;

    assign Res_Valid = (state_q == StDone);
    assign Res_Data  = res_data_q;
    assign Res_Id    = res_id_q;

    always_comb begin
        state_d    = state_q;
        op_x_d     = op_x_q;
        op_sa_d    = op_sa_q;
        op_code_d  = op_code_q;
        op_id_d    = op_id_q;
        partial_d  = partial_q;
        rr_last_d  = rr_last_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        Req0_Ready = 1'b0;
        Req1_Ready = 1'b0;
        Sh_X       = '0;
        Sh_Sa      = '0;
        Sh_Arith   = 1'b0;
        Sh_Right   = 1'b0;

        case (state_q)
            StIdle: begin
                // Ready is gated by Rst so it stays low throughout reset.
                if (any_valid && !Rst) begin
                    Req0_Ready = !gnt_id;
                    Req1_Ready = gnt_id;
                    op_x_d     = gnt_id ? Req1_X  : Req0_X;
                    op_sa_d    = gnt_id ? Req1_Sa : Req0_Sa;
                    op_code_d  = gnt_id ? Req1_Op : Req0_Op;
                    op_id_d    = gnt_id;
                    rr_last_d  = gnt_id;
                    state_d    = StPass1;
                end
            end
            StPass1: begin
                Sh_X  = op_x_q;
                Sh_Sa = op_sa_q;
                case (op_code_q)
                    OpSrl:   Sh_Right = 1'b1;
                    OpSra: begin
                        Sh_Right = 1'b1;
                        Sh_Arith = 1'b1;
                    end
                    OpRor:   Sh_Right = 1'b1;
                    default: ;
                endcase
                if (op_code_q == OpRor && op_sa_q != '0) begin
                    partial_d = Sh_Result;
                    state_d   = StPass2;
                end else begin
                    // Rotate by zero is the operand itself; skip the second pass.
                    res_data_d = (op_code_q == OpRor) ? op_x_q : Sh_Result;
                    res_id_d   = op_id_q;
                    state_d    = StDone;
                end
            end
            StPass2: begin
                Sh_X       = op_x_q;
                Sh_Sa      = -op_sa_q;
                res_data_d = Sh_Result | partial_q;
                res_id_d   = op_id_q;
                state_d    = StDone;
            end
            StDone: begin
                if (Res_Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StIdle;
            op_x_q     <= '0;
            op_sa_q    <= '0;
            op_code_q  <= '0;
            op_id_q    <= 1'b0;
            partial_q  <= '0;
            rr_last_q  <= 1'b1;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_x_q     <= op_x_d;
            op_sa_q    <= op_sa_d;
            op_code_q  <= op_code_d;
            op_id_q    <= op_id_d;
            partial_q  <= partial_d;
            rr_last_q  <= rr_last_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

endmodule
